booth_mult_sequencer: RTL and testbench

Upstream/downstream wrapper for the radix-2 16-bit Booth multiplier (boothmultiplier). It accepts an operand pair over a valid/ready handshake and generates the multiplier's start pulse. It presents multiplicand then multiplier serially on the shared data bus, waits the fixed compute latency, and captures the 2W-bit product into a one-entry output buffer with its own valid/ready handshake. This turns the multiplier's bare start/data_in/result interface into a stream interface for the datapath.

---
 rtl/booth_pkg.sv | 16 +
 rtl/booth_out_buf.sv | 27 ++
 rtl/booth_mult_sequencer.sv | 118 +++++++++++
 tb/tb_booth_mult_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier stream wrapper: FSM state
// encoding and default sizing.
package booth_pkg;

    localparam int DEFAULT_WIDTH       = 16;
    localparam int DEFAULT_CALC_CYCLES = 17;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        LOAD_A = 3'd2,
        LOAD_B = 3'd3,
        WAIT   = 3'd4
    } state_t;

endpackage

// File: rtl/booth_out_buf.sv
// One-entry valid/ready holding register for the product. A capture always
// finds the buffer empty, because a new operation is only accepted once it drains.
module booth_out_buf #(
    parameter int PW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          capture,
    input  logic [PW-1:0] capture_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [PW-1:0] out_result
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
        end else if (capture) begin
            out_valid  <= 1'b1;
            out_result <= capture_data;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/booth_mult_sequencer.sv
// Stream wrapper around the radix-2 Booth multiplier: accepts an operand pair,
// drives start/data serially, waits the compute latency and buffers the product.
module booth_mult_sequencer
    import booth_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int CALC_CYCLES = DEFAULT_CALC_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic                 mult_start,
    output logic [WIDTH-1:0]     mult_data,
    input  logic [2*WIDTH-1:0]   mult_result,
    output logic                 busy,
    output logic [2:0]           dbg_state
);

    localparam int CNT_W = $clog2(CALC_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CALC_CYCLES - 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid holds its payload until that edge and never depends on ready.

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_d;
    logic [WIDTH-1:0]   data_d;
    logic               capture;
    logic               accept;

    assign in_ready  = rst_n && (state_q == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        data_d  = '0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    start_d = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                data_d  = a_q;
                state_d = LOAD_A;
            end
            LOAD_A: begin
                data_d  = b_q;
                state_d = LOAD_B;
            end
            LOAD_B: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // mult_start/mult_data are computed one cycle ahead so the multiplier sees
    // flop outputs that line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            mult_start <= 1'b0;
            mult_data  <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            mult_start <= start_d;
            mult_data  <= data_d;
        end
    end

    booth_out_buf #(
        .PW(2*WIDTH)
    ) u_out_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .capture      (capture),
        .capture_data (mult_result),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_result   (out_result)
    );

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// Directed bench for booth_mult_sequencer with a behavioural multiplier that
// presents a*b only late in the compute window.
module tb_booth_mult_sequencer;

    localparam int WIDTH       = 16;
    localparam int CALC_CYCLES = 17;
    localparam int LAT         = 3 + CALC_CYCLES;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a = '0;
    logic [WIDTH-1:0]   in_b = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [2*WIDTH-1:0] out_result;
    logic               mult_start;
    logic [WIDTH-1:0]   mult_data;
    logic [2*WIDTH-1:0] mult_result;
    logic               busy;
    logic [2:0]         dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    booth_mult_sequencer #(
        .WIDTH(WIDTH),
        .CALC_CYCLES(CALC_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .mult_start  (mult_start),
        .mult_data   (mult_data),
        .mult_result (mult_result),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // behavioural multiplier: result is garbage until the last cycle before capture
    int               m_ph;
    int               m_dly;
    logic [WIDTH-1:0] m_a, m_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph        <= 0;
            m_dly       <= 0;
            m_a         <= '0;
            m_b         <= '0;
            mult_result <= 32'hDEAD_BEEF;
        end else begin
            case (m_ph)
                0: if (mult_start) begin
                    m_ph        <= 1;
                    mult_result <= 32'hDEAD_BEEF;
                end
                1: begin
                    m_a  <= mult_data;
                    m_ph <= 2;
                end
                2: begin
                    if (CALC_CYCLES == 1) begin
                        mult_result <= 32'($signed(m_a) * $signed(mult_data));
                        m_ph        <= 0;
                    end else begin
                        m_b   <= mult_data;
                        m_dly <= CALC_CYCLES - 1;
                        m_ph  <= 3;
                    end
                end
                default: begin
                    if (m_dly == 1) begin
                        mult_result <= 32'($signed(m_a) * $signed(m_b));
                        m_ph        <= 0;
                    end
                    m_dly <= m_dly - 1;
                end
            endcase
        end
    end

    // scoreboard
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jumble();
        in_valid = 1'($urandom_range(0, 1));
        in_a     = 16'($urandom_range(0, 65535));
        in_b     = 16'($urandom_range(0, 65535));
    endtask

    // Present a pair, pass the accept edge and check the serial operand frame.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit scribble);
        int n;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("send_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        if (scribble) jumble();
        check("start_pulse", mult_start, 1);
        check("start_data", mult_data, 0);
        check("start_busy", busy, 1);
        tick();
        if (scribble) jumble();
        check("load_a_start", mult_start, 0);
        check("load_a_data", mult_data, a);
        tick();
        if (scribble) jumble();
        check("load_b_data", mult_data, b);
        tick();
        if (scribble) jumble();
        check("wait_data", mult_data, 0);
    endtask

    task automatic wait_result(input logic [2*WIDTH-1:0] exp, input string tag, input bit scribble);
        int n;
        n = 3;
        while (!out_valid && n < LAT + 20) begin
            if (scribble) jumble();
            tick();
            n++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, n, LAT);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_result"}, out_result, exp);
    endtask

    initial begin
        logic [2*WIDTH-1:0] held;
        int n;

        // reset state
        #3;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_mult_start", mult_start, 0);
        check("rst_mult_data", mult_data, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        // single op: 10 * -13
        out_ready = 1'b1;
        send(16'd10, 16'hFFF3, 1'b0);
        wait_result(32'hFFFF_FF7E, "single", 1'b0);
        tick();
        check("single_drained", out_valid, 0);

        // corner operands
        send(16'h8000, 16'h8000, 1'b0);
        wait_result(32'h4000_0000, "min_min", 1'b0);
        send(16'h7FFF, 16'hFFFF, 1'b0);
        wait_result(32'hFFFF_8001, "max_m1", 1'b0);
        send(16'd0, 16'd1234, 1'b0);
        wait_result(32'h0000_0000, "zero", 1'b0);
        tick();

        // backpressure: -2 * 9 held while a second pair waits
        out_ready = 1'b0;
        send(16'hFFFE, 16'd9, 1'b0);
        wait_result(32'hFFFF_FFEE, "bp_first", 1'b0);
        held     = out_result;
        in_a     = 16'd3;
        in_b     = 16'd4;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_stable", out_result, held);
            check("bp_valid", out_valid, 1);
            check("bp_no_start", busy, 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_drained", out_valid, 0);
        check("bp_second_start", mult_start, 1);
        tick();
        tick();
        tick();
        wait_result(32'h0000_000C, "bp_second", 1'b0);
        tick();

        // back-to-back with in_valid held: 2*3 then -5*7
        in_a     = 16'd2;
        in_b     = 16'd3;
        in_valid = 1'b1;
        check("b2b_ready", in_ready, 1);
        tick();
        check("b2b_first_start", mult_start, 1);
        in_a = 16'hFFFB;
        in_b = 16'd7;
        n = 0;
        while (!out_valid && n < LAT + 20) begin
            tick();
            n++;
        end
        check("b2b_first_latency", n, LAT);
        check("b2b_first_result", out_result, 32'h0000_0006);
        check("b2b_ready_on_drain", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("b2b_drain", out_valid, 0);
        check("b2b_second_start", mult_start, 1);
        tick();
        check("b2b_second_a", mult_data, 16'hFFFB);
        tick();
        check("b2b_second_b", mult_data, 16'd7);
        tick();
        wait_result(32'hFFFF_FFDD, "b2b_second", 1'b0);
        tick();

        // reset while counting (counter at 5)
        send(16'd100, 16'd3, 1'b0);
        repeat (11) tick();
        check("pre_abort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_out_result", out_result, 0);
        check("abort_mult_start", mult_start, 0);
        check("abort_mult_data", mult_data, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("abort_release_ready", in_ready, 1);
        repeat (25) tick();
        check("abort_no_result", out_valid, 0);
        send(16'd7, 16'hFFF9, 1'b0);
        wait_result(32'hFFFF_FFCF, "after_abort", 1'b0);
        tick();

        // input noise while busy: 123 * -45
        send(16'd123, 16'hFFD3, 1'b1);
        wait_result(32'hFFFF_EA61, "noise", 1'b1);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
